// File: rtl/bconv3x3_stream.sv
// Binarized 3x3 convolution over a raster 1-bit stream: two line buffers, XNOR-popcount, threshold.
// Define BCONV_POPCNT_OUT_EN to expose the registered popcount on oPOPCNT.
module bconv3x3_stream #(
  parameter int IW  = 32,
  parameter int IH  = 32,
  parameter int CWB = 5,
  parameter int RWB = 5
) (
  input  logic       iRSTn,
  input  logic       iCLK,
  input  logic       iEN,
  input  logic       iCLR,
  input  logic       iDATA,
  input  logic [8:0] iWEIGHT,
  input  logic [3:0] iTHRESH,
  output logic       oDATA,
  output logic       oVALID
`ifdef BCONV_POPCNT_OUT_EN
  , output logic [3:0] oPOPCNT
`endif
);

  logic [CWB-1:0] r_col;
  logic [RWB-1:0] r_row;
  logic [IW-1:0]  r_lb1;
  logic [IW-1:0]  r_lb2;
  // Only the two older window columns are stored; the newest column is the live {LB2, LB1, iDATA}.
  logic [5:0]     r_win;
  logic           r_data;
  logic           r_valid;
`ifdef BCONV_POPCNT_OUT_EN
  logic [3:0]     r_pop;
`endif

  logic           w_lb1;
  logic           w_lb2;
  logic [8:0]     w_win;
  logic [8:0]     w_match;
  logic [3:0]     w_pop;
  logic           w_res;
  logic           w_col_last;
  logic           w_row_last;
  logic           w_wvalid;

  assign w_lb1      = r_lb1[IW-1];
  assign w_lb2      = r_lb2[IW-1];
  assign w_win      = {r_win[5:4], w_lb2, r_win[3:2], w_lb1, r_win[1:0], iDATA};
  assign w_match    = ~(w_win ^ iWEIGHT);
  assign w_res      = (w_pop >= iTHRESH);
  assign w_col_last = (r_col == CWB'(IW - 1));
  assign w_row_last = (r_row == RWB'(IH - 1));
  assign w_wvalid   = (r_row >= RWB'(2)) && (r_col >= CWB'(2));

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < 9; i++) begin
      w_pop = w_pop + 4'(w_match[i]);
    end
  end

  always_ff @(posedge iCLK or negedge iRSTn) begin
    if (!iRSTn) begin
      r_col   <= '0;
      r_row   <= '0;
      r_lb1   <= '0;
      r_lb2   <= '0;
      r_win   <= '0;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
`ifdef BCONV_POPCNT_OUT_EN
      r_pop   <= '0;
`endif
    end else if (iCLR) begin
      r_col   <= '0;
      r_row   <= '0;
      r_lb1   <= '0;
      r_lb2   <= '0;
      r_win   <= '0;
      r_data  <= 1'b0;
      r_valid <= 1'b0;
`ifdef BCONV_POPCNT_OUT_EN
      r_pop   <= '0;
`endif
    end else begin
      r_valid <= iEN && w_wvalid;
      if (iEN) begin
        r_lb1 <= {r_lb1[IW-2:0], iDATA};
        r_lb2 <= {r_lb2[IW-2:0], w_lb1};
        r_win <= {w_win[7:6], w_win[4:3], w_win[1:0]};
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_wvalid) begin
          r_data <= w_res;
`ifdef BCONV_POPCNT_OUT_EN
          r_pop  <= w_pop;
`endif
        end
      end
    end
  end

  assign oDATA  = r_data;
  assign oVALID = r_valid;
`ifdef BCONV_POPCNT_OUT_EN
  assign oPOPCNT = r_pop;
`endif

endmodule

// File: tb/tb_bconv3x3_stream.sv
// Directed bench for bconv3x3_stream on a 4x4 image: table vectors, gaps, back-to-back frames, clear/reset.
module tb_bconv3x3_stream;

  logic       iRSTn;
  logic       iCLK;
  logic       iEN;
  logic       iCLR;
  logic       iDATA;
  logic [8:0] iWEIGHT;
  logic [3:0] iTHRESH;
  logic       oDATA;
  logic       oVALID;
`ifdef BCONV_POPCNT_OUT_EN
  logic [3:0] oPOPCNT;
  logic [15:0] got_pop;
`endif

  int errors = 0;
  int checks = 0;

  bconv3x3_stream #(.IW(4), .IH(4), .CWB(2), .RWB(2)) dut (
    .iRSTn   (iRSTn),
    .iCLK    (iCLK),
    .iEN     (iEN),
    .iCLR    (iCLR),
    .iDATA   (iDATA),
    .iWEIGHT (iWEIGHT),
    .iTHRESH (iTHRESH),
    .oDATA   (oDATA),
    .oVALID  (oVALID)
`ifdef BCONV_POPCNT_OUT_EN
    , .oPOPCNT (oPOPCNT)
`endif
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [15:0] img;   // bit r*4+c
    logic [8:0]  w;
    logic [3:0]  th;
    logic [3:0]  exp;   // bit k: window (2+k/2, 2+k%2)
    logic [15:0] pop;   // nibble k: popcount of window k
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [15:0] img, input logic [8:0] w, input logic [3:0] th);
    logic [3:0] res;
    int r, c, pop;
    res = '0;
    for (int k = 0; k < 4; k++) begin
      r = 2 + k / 2;
      c = 2 + k % 2;
      pop = 0;
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          if (img[(r - 2 + dr) * 4 + (c - 2 + dc)] == w[8 - (dr * 3 + dc)]) pop++;
      res[k] = (pop >= int'(th));
    end
    return res;
  endfunction

  task automatic idle(input string nm, input int n);
    iEN = 1'b0;
    for (int j = 0; j < n; j++) begin
      @(negedge iCLK);
      chk({nm, "_idle_valid"}, 32'(oVALID), 0);
    end
  endtask

  // Drives npix pixels and checks oVALID one cycle after every pixel; optional random idle gaps.
  task automatic run_frame(input string nm, input logic [15:0] img, input logic [8:0] w,
                           input logic [3:0] th, input bit gaps, input int npix,
                           output logic [3:0] got, output int nv);
    int ng, k;
    logic expv;
    got = '0;
    nv = 0;
    iWEIGHT = w;
    iTHRESH = th;
    for (int i = 0; i < npix; i++) begin
      if (gaps) begin
        ng = $urandom_range(0, 2);
        for (int g = 0; g < ng; g++) begin
          iEN = 1'b0;
          @(negedge iCLK);
          chk($sformatf("%s_gap_valid_px%0d", nm, i), 32'(oVALID), 0);
        end
      end
      iEN = 1'b1;
      iDATA = img[i];
      @(negedge iCLK);
      expv = (i / 4 >= 2) && (i % 4 >= 2);
      chk($sformatf("%s_valid_px%0d", nm, i), 32'(oVALID), 32'(expv));
      if (oVALID && expv) begin
        k = (i / 4 - 2) * 2 + (i % 4 - 2);
        got[k] = oDATA;
`ifdef BCONV_POPCNT_OUT_EN
        got_pop[k*4 +: 4] = oPOPCNT;
`endif
      end
      if (oVALID) nv++;
    end
    iEN = 1'b0;
  endtask

  vec_t vecs [10];
  logic [3:0]  got;
  logic [15:0] img;
  logic [8:0]  w;
  logic [3:0]  th;
  int nv;

  initial begin
    vecs[0] = '{16'hFFFF, 9'h1FF, 4'd9,  4'b1111, 16'h9999};
    vecs[1] = '{16'hFFFF, 9'h000, 4'd1,  4'b0000, 16'h0000};
    vecs[2] = '{16'hFFFF, 9'h000, 4'd0,  4'b1111, 16'h0000};
    vecs[3] = '{16'h5A5A, 9'h155, 4'd9,  4'b0110, 16'h0990};
    vecs[4] = '{16'h0001, 9'h100, 4'd9,  4'b0001, 16'h8889};
    vecs[5] = '{16'h8000, 9'h001, 4'd9,  4'b1000, 16'h9888};
    vecs[6] = '{16'hFFFF, 9'h1FF, 4'd10, 4'b0000, 16'h9999};
    vecs[7] = '{16'hFFFF, 9'h1FF, 4'd15, 4'b0000, 16'h9999};
    vecs[8] = '{16'hFFFF, 9'h1F0, 4'd5,  4'b1111, 16'h5555};
    vecs[9] = '{16'hFFFF, 9'h1F0, 4'd6,  4'b0000, 16'h5555};

    iRSTn = 1'b0;
    iEN = 1'b0;
    iCLR = 1'b0;
    iDATA = 1'b0;
    iWEIGHT = '0;
    iTHRESH = '0;
    @(negedge iCLK);
    @(negedge iCLK);
    chk("reset_valid", 32'(oVALID), 0);
    chk("reset_data", 32'(oDATA), 0);
    iRSTn = 1'b1;
    @(negedge iCLK);

    for (int t = 0; t < 10; t++) begin
      run_frame($sformatf("vec%0d", t), vecs[t].img, vecs[t].w, vecs[t].th, 1'b0, 16, got, nv);
      idle($sformatf("vec%0d", t), 1);
      chk($sformatf("vec%0d_data", t), 32'(got), 32'(vecs[t].exp));
      chk($sformatf("vec%0d_count", t), 32'(nv), 4);
`ifdef BCONV_POPCNT_OUT_EN
      chk($sformatf("vec%0d_pop", t), 32'(got_pop), 32'(vecs[t].pop));
`endif
    end

    // Two frames back to back, no idle cycle between them
    run_frame("b2b_f1", 16'hFFFF, 9'h1FF, 4'd9, 1'b0, 16, got, nv);
    chk("b2b_f1_data", 32'(got), 32'hF);
    run_frame("b2b_f2", 16'h5A5A, 9'h155, 4'd9, 1'b0, 16, got, nv);
    chk("b2b_f2_data", 32'(got), 32'h6);
    chk("b2b_f2_count", 32'(nv), 4);
    idle("b2b", 1);

    for (int t = 0; t < 4; t++) begin
      img = 16'($urandom);
      w = 9'($urandom);
      th = 4'($urandom_range(0, 10));
      run_frame($sformatf("rnd%0d", t), img, w, th, 1'b1, 16, got, nv);
      idle($sformatf("rnd%0d", t), 2);
      chk($sformatf("rnd%0d_data", t), 32'(got), 32'(model(img, w, th)));
      chk($sformatf("rnd%0d_count", t), 32'(nv), 4);
    end

    // iCLR together with iEN after pixel (2,3)
    run_frame("clr_pre", 16'hFFFF, 9'h1FF, 4'd9, 1'b0, 12, got, nv);
    chk("clr_pre_data", 32'(got[1:0]), 32'h3);
    iEN = 1'b1;
    iDATA = 1'b1;
    iCLR = 1'b1;
    @(negedge iCLK);
    chk("clr_valid", 32'(oVALID), 0);
    chk("clr_data", 32'(oDATA), 0);
    iCLR = 1'b0;
    run_frame("clr_post", 16'h5A5A, 9'h155, 4'd9, 1'b0, 16, got, nv);
    idle("clr_post", 1);
    chk("clr_post_data", 32'(got), 32'h6);
    chk("clr_post_count", 32'(nv), 4);

    // Asynchronous reset mid-frame after pixel (2,3)
    run_frame("rst_pre", 16'hFFFF, 9'h1FF, 4'd9, 1'b0, 12, got, nv);
    chk("rst_pre_data", 32'(got[1:0]), 32'h3);
    #2 iRSTn = 1'b0;
    #1;
    chk("rst_valid", 32'(oVALID), 0);
    chk("rst_data", 32'(oDATA), 0);
    #1 iRSTn = 1'b1;
    run_frame("rst_post", 16'h5A5A, 9'h155, 4'd9, 1'b0, 16, got, nv);
    idle("rst_post", 1);
    chk("rst_post_data", 32'(got), 32'h6);
    chk("rst_post_count", 32'(nv), 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
